// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small byte FIFO: 8 data bits, LSB first, one stop bit.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       txclk,
    input  logic       reset_n,
    input  logic       tx_enable,
    input  logic       ld_tx_data,
    input  logic [7:0] tx_data,
    input  logic       clr_over_run,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic       tx_over_run
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [15:0]   BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FIFO_FULL   = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t         state;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [15:0]    baud_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift_reg;
    logic           push;
    logic           pop;
`ifdef UART_TX_PARITY_EN
    logic           parity_bit;
`endif

    // Readiness comes from the registered count only, so a pop never frees room in the same cycle.
    assign tx_ready = (count != FIFO_FULL);
    assign push     = ld_tx_data && tx_ready;
    assign pop      = (state == IDLE) && tx_enable && (count != '0);
    assign tx_busy  = (state != IDLE);
    assign tx_empty = (count == '0) && (state == IDLE);

    always_ff @(posedge txclk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // A dropped write in the same cycle as a clear leaves the flag set.
    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            tx_over_run <= 1'b0;
        end else if (ld_tx_data && !tx_ready) begin
            tx_over_run <= 1'b1;
        end else if (clr_over_run) begin
            tx_over_run <= 1'b0;
        end
    end

    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tx_out    <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state     <= START;
                        tx_out    <= 1'b0;
                        baud_cnt  <= BAUD_RELOAD;
                        shift_reg <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^mem[rd_ptr];
`endif
                    end
                end
                START: begin
                    if (baud_cnt == '0) begin
                        state     <= DATA;
                        tx_out    <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_idx   <= '0;
                        baud_cnt  <= BAUD_RELOAD;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state  <= PARITY;
                            tx_out <= parity_bit;
`else
                            state  <= STOP;
                            tx_out <= 1'b1;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            tx_out    <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_cnt == '0) begin
                        state    <= STOP;
                        tx_out   <= 1'b1;
                        baud_cnt <= BAUD_RELOAD;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (baud_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Honours UART_TX_PARITY_EN to expect the 11-bit frame and run the parity cases.
module tb_uart_tx_fifo;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int FRAME_BITS = 10;
    localparam bit PAR = 1'b0;
`endif

    logic       txclk;
    logic       reset_n;
    logic       tx_enable;
    logic       ld_tx_data;
    logic [7:0] tx_data;
    logic       clr_over_run;
    logic       tx_ready;
    logic       tx_out;
    logic       tx_empty;
    logic       tx_busy;
    logic       tx_over_run;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] last_obs;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .txclk        (txclk),
        .reset_n      (reset_n),
        .tx_enable    (tx_enable),
        .ld_tx_data   (ld_tx_data),
        .tx_data      (tx_data),
        .clr_over_run (clr_over_run),
        .tx_ready     (tx_ready),
        .tx_out       (tx_out),
        .tx_empty     (tx_empty),
        .tx_busy      (tx_busy),
        .tx_over_run  (tx_over_run)
    );

    initial txclk = 1'b0;
    always #5 txclk = ~txclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        ld_tx_data = 1'b1;
        tx_data    = b;
        @(negedge txclk);
        ld_tx_data = 1'b0;
    endtask

    task automatic watch_idle(input int n, input string tag);
        int lows;
        lows = 0;
        repeat (n) begin
            if (tx_out !== 1'b1) lows++;
            @(negedge txclk);
        end
        check(tag, 64'(lows), 64'd0);
    endtask

    // Waits (bounded) for the start bit, then samples every cycle of the frame.
    task automatic frame(input logic [7:0] b, input string tag, input int drop_at, output int gap);
        logic [63:0] obs;
        logic [63:0] exp;
        int t;
        gap = 0;
        while (tx_out !== 1'b0 && gap < 400) begin
            gap++;
            @(negedge txclk);
        end
        check1({tag, "_start"}, tx_out, 1'b0);
        obs = '0;
        exp = '0;
        for (int k = 0; k < FRAME_BITS * CPB; k++) begin
            t = k / CPB;
            if (t == 0)             exp[k] = 1'b0;
            else if (t <= 8)        exp[k] = b[t-1];
            else if (PAR && t == 9) exp[k] = ^b;
            else                    exp[k] = 1'b1;
            obs[k] = tx_out;
            if (k == drop_at) tx_enable = 1'b0;
            @(negedge txclk);
        end
        last_obs = obs;
        check(tag, obs, exp);
    endtask

    initial begin
        int gap;
        int w;
        reset_n      = 1'b0;
        tx_enable    = 1'b0;
        ld_tx_data   = 1'b0;
        tx_data      = 8'h00;
        clr_over_run = 1'b0;
        repeat (3) @(negedge txclk);
        check1("rst_tx_out", tx_out, 1'b1);
        check1("rst_empty", tx_empty, 1'b1);
        check1("rst_ready", tx_ready, 1'b1);
        check1("rst_busy", tx_busy, 1'b0);
        check1("rst_ovr", tx_over_run, 1'b0);
        reset_n = 1'b1;
        @(negedge txclk);

        // Single byte 0xA5
        tx_enable = 1'b1;
        push_byte(8'hA5);
        frame(8'hA5, "frame_a5", -1, gap);
        check1("a5_empty_after", tx_empty, 1'b1);
        check1("a5_busy_after", tx_busy, 1'b0);

        // Overrun with FIFO full and transmitter held off
        tx_enable = 1'b0;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        check1("ready_at3", tx_ready, 1'b1);
        push_byte(8'h44);
        check1("ready_at4", tx_ready, 1'b0);
        check1("ovr_at4", tx_over_run, 1'b0);
        check1("empty_full", tx_empty, 1'b0);
        push_byte(8'h55);
        check1("ovr_at5", tx_over_run, 1'b1);
        clr_over_run = 1'b1;
        push_byte(8'h77);
        clr_over_run = 1'b0;
        check1("ovr_set_wins", tx_over_run, 1'b1);
        clr_over_run = 1'b1;
        @(negedge txclk);
        clr_over_run = 1'b0;
        check1("ovr_cleared", tx_over_run, 1'b0);
        // Write in the same cycle as the first pop of a full FIFO must be dropped
        tx_enable = 1'b1;
        push_byte(8'h66);
        check1("pop_no_ready_ovr", tx_over_run, 1'b1);
        check1("ready_after_pop", tx_ready, 1'b1);
        check1("busy_in_frame", tx_busy, 1'b1);
        frame(8'h11, "full_f0", -1, gap);
        frame(8'h22, "full_f1", -1, gap);
        check("full_gap1", 64'(gap), 64'd1);
        frame(8'h33, "full_f2", -1, gap);
        frame(8'h44, "full_f3", -1, gap);
        check1("full_empty_end", tx_empty, 1'b1);
        watch_idle(20, "no_dropped_bytes");
        tx_enable    = 1'b0;
        clr_over_run = 1'b1;
        @(negedge txclk);
        clr_over_run = 1'b0;
        check1("ovr_cleared2", tx_over_run, 1'b0);

        // FIFO order and one-cycle inter-frame gap
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h3C);
        check1("queued_busy", tx_busy, 1'b0);
        check1("queued_empty", tx_empty, 1'b0);
        watch_idle(8, "held_while_disabled");
        tx_enable = 1'b1;
        frame(8'h00, "ord_f0", -1, gap);
        frame(8'hFF, "ord_f1", -1, gap);
        check("ord_gap1", 64'(gap), 64'd1);
        frame(8'h3C, "ord_f2", -1, gap);
        check("ord_gap2", 64'(gap), 64'd1);

        // Enable dropped during data bit 3; the simultaneous push/pop keeps count at 1
        push_byte(8'h5A);
        push_byte(8'hC3);
        frame(8'h5A, "drop_f0", 4 * CPB + 1, gap);
        check1("drop_busy", tx_busy, 1'b0);
        check1("drop_empty", tx_empty, 1'b0);
        watch_idle(30, "drop_held");
        tx_enable = 1'b1;
        frame(8'hC3, "drop_f1", -1, gap);

        // Reset while in DATA
        push_byte(8'h96);
        push_byte(8'h69);
        w = 0;
        while (tx_out !== 1'b0 && w < 100) begin
            w++;
            @(negedge txclk);
        end
        check1("mid_start", tx_out, 1'b0);
        repeat (CPB + 6) @(negedge txclk);
        reset_n = 1'b0;
        #1;
        check1("mid_rst_tx_out", tx_out, 1'b1);
        check1("mid_rst_empty", tx_empty, 1'b1);
        check1("mid_rst_busy", tx_busy, 1'b0);
        check1("mid_rst_ready", tx_ready, 1'b1);
        @(negedge txclk);
        reset_n = 1'b1;
        watch_idle(12, "rst_discarded");
        push_byte(8'h3D);
        frame(8'h3D, "post_rst", -1, gap);
        check1("post_rst_empty", tx_empty, 1'b1);

`ifdef UART_TX_PARITY_EN
        push_byte(8'h07);
        frame(8'h07, "par_07", -1, gap);
        check1("par_07_bit", last_obs[9*CPB], 1'b1);
        push_byte(8'h03);
        frame(8'h03, "par_03", -1, gap);
        check1("par_03_bit", last_obs[9*CPB], 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: txclk cycles per serial bit, legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: byte entries in the transmit FIFO, power of two, 2..16.
REQ-003 SHALL have port txclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port tx_enable, input, 1 bit: permits new frames to start.
REQ-006 SHALL have port ld_tx_data, input, 1 bit: write strobe for tx_data.
REQ-007 SHALL have port tx_data, input, 8 bits: byte to queue.
REQ-008 SHALL have port clr_over_run, input, 1 bit: clears tx_over_run.
REQ-009 SHALL have port tx_ready, output, 1 bit: FIFO not full.
REQ-010 SHALL have port tx_out, output, 1 bit: serial line, idle high.
REQ-011 SHALL have port tx_empty, output, 1 bit: FIFO empty and FSM in IDLE.
REQ-012 SHALL have port tx_busy, output, 1 bit: FSM not in IDLE.
REQ-013 SHALL have port tx_over_run, output, 1 bit: sticky flag, a write was dropped.

Function
REQ-014 SHALL accept a byte into the FIFO on any edge where ld_tx_data=1 and tx_ready=1.
REQ-015 SHALL compute tx_ready from the registered FIFO count only; a same-cycle pop SHALL NOT make a full FIFO ready.
REQ-016 SHALL drop the byte and set tx_over_run when ld_tx_data=1 and tx_ready=0; FIFO contents SHALL be unchanged.
REQ-017 SHALL clear tx_over_run on clr_over_run=1; if a set event coincides with the clear, set wins.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-019 SHALL, in IDLE with tx_enable=1 and FIFO non-empty, pop the head byte into a shift register and enter START on the next edge.
REQ-020 SHALL drive tx_out registered: 0 in START, data bits LSB-first in DATA, 1 in STOP and IDLE.
REQ-021 SHALL hold each state's bit for exactly CLKS_PER_BIT cycles using a baud counter that reloads at each bit boundary.
REQ-022 SHALL use a 3-bit bit index in DATA and leave DATA after bit 7.
REQ-023 SHALL, at the end of STOP, go to IDLE and take one idle cycle before the next START; back-to-back frames are therefore (10 bit-times + 1 cycle) apart.
REQ-024 SHALL finish the current frame when tx_enable falls mid-frame, and SHALL NOT start a new frame while tx_enable=0.
REQ-025 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH, with a count width of clog2(FIFO_DEPTH)+1.
REQ-026 SHALL support a simultaneous push and pop at count 1..DEPTH-1, leaving the count unchanged.

Reset
REQ-027 SHALL, on reset_n=0, asynchronously force: FSM=IDLE, tx_out=1, FIFO count=0, both pointers=0, tx_over_run=0, tx_busy=0, tx_empty=1, tx_ready=1.
REQ-028 SHALL discard a frame that is in progress at reset, with tx_out returning high immediately and no glitch low.
REQ-029 SHALL need no reset on the FIFO data storage.

Configuration
REQ-030 SHALL, with UART_TX_PARITY_EN defined, insert a PARITY state between DATA and STOP that sends the even parity (XOR) of the 8 data bits for one bit-time, making a frame 11 bit-times.
REQ-031 SHALL, without UART_TX_PARITY_EN, have no PARITY state or parity logic, making a frame 10 bit-times.

Verification
REQ-032 SHALL cover a single byte: CLKS_PER_BIT=4, write 0xA5 with tx_enable=1 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit; tx_empty=1 after STOP.
REQ-033 SHALL cover overrun: DEPTH=4, tx_enable=0, write 5 bytes -> first 4 accepted; tx_ready=0 after the 4th; tx_over_run=1 after the 5th; clr_over_run -> 0.
REQ-034 SHALL cover the FIFO order and gap: queue 0x00, 0xFF, 0x3C, then enable -> three frames in order, each separated by exactly 1 idle cycle.
REQ-035 SHALL cover enable drop: deassert tx_enable during bit 3 of a 2-byte burst -> first frame completes; second is held until tx_enable=1.
REQ-036 SHALL cover reset mid-frame: assert reset_n=0 in DATA -> tx_out=1 and tx_empty=1 immediately; a byte queued after release is sent correctly.
REQ-037 SHALL cover parity with UART_TX_PARITY_EN: byte 0x07 -> parity bit 1 before stop; byte 0x03 -> parity bit 0.
